ram_ctrl_sync: RTL

//   Parametrised single-port synchronous main memory for the CPU datapath. Replaces the fixed
//   512x32 RAM and sits between the MAR/MDR and the control unit.

---
 rtl/ram_ctrl_sync.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ram_ctrl_sync.sv
// ram_ctrl_sync: single-port synchronous main memory with per-byte write enables,
// configurable read latency (Ready/Done handshake), zero-fill after every reset and
// out-of-range address detection.
module ram_ctrl_sync #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Read,
    input  logic                Write,
    input  logic [ADDR_W-1:0]   Address,
    input  logic [DATA_W-1:0]   Mdatain,
    input  logic [DATA_W/8-1:0] ByteEn,
    output logic                Ready,
    output logic                Done,
    output logic                Err,
    output logic [DATA_W-1:0]   data_output
);

    localparam int unsigned NLANES = DATA_W / 8;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so DEPTH == 2**ADDR_W is representable; Err then can never fire.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
    // Edges remaining in RD_WAIT after acceptance; the last one loads data_output.
    localparam logic [1:0]        WAIT_INIT = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StRdWait
    } state_e;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic              rerr_q, rerr_d;
    logic [1:0]        cnt_q, cnt_d;

    logic              oor;
    logic              wr_en;
    logic [IDX_W-1:0]  addr_idx;
    logic [IDX_W-1:0]  fill_idx;
    logic [DATA_W-1:0] rd_word;

    assign oor      = {1'b0, Address} >= DEPTH_X;
    assign addr_idx = Address[IDX_W-1:0];
    assign fill_idx = fill_q[IDX_W-1:0];
    assign wr_en    = (state_q == StIdle) && Write && !oor;

    // Array read of the requested word; out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (!oor) begin
            rd_word = mem[addr_idx];
        end
    end

    // Storage: zero-fill one word per edge in INIT, byte-lane merge on accepted writes.
    always_ff @(posedge Clock) begin
        if (state_q == StInit) begin
            mem[fill_idx] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NLANES; i++) begin
                if (ByteEn[i]) begin
                    mem[addr_idx][8*i +: 8] <= Mdatain[8*i +: 8];
                end
            end
        end
    end

    // Control state register; reset discards any in-flight read and restarts the fill.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StInit;
            fill_q  <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            rbuf_q  <= '0;
            rerr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            rbuf_q  <= rbuf_d;
            rerr_q  <= rerr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: fill sequencing, request acceptance and read-latency countdown.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        dout_d  = dout_q;
        rbuf_d  = rbuf_q;
        rerr_d  = rerr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StInit: begin
                fill_d = fill_q + PTR_ONE;
                if (fill_q == LAST_WORD) begin
                    fill_d  = '0;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StIdle: begin
                // Write wins a Read/Write collision; the read is dropped.
                if (Write) begin
                    done_d = 1'b1;
                    err_d  = oor;
                end else if (Read) begin
                    if (RD_LAT == 1) begin
                        dout_d = rd_word;
                        done_d = 1'b1;
                        err_d  = oor;
                    end else begin
                        rbuf_d  = rd_word;
                        rerr_d  = oor;
                        cnt_d   = WAIT_INIT;
                        ready_d = 1'b0;
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                if (cnt_q == 2'd1) begin
                    dout_d  = rbuf_q;
                    done_d  = 1'b1;
                    err_d   = rerr_q;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = StInit;
                fill_d  = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign Ready       = ready_q;
    assign Done        = done_q;
    assign Err         = err_q;
    assign data_output = dout_q;

endmodule
